// File: rtl/right_shift_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : right_shift_sequencer
// Description : Multi-bit right-shift engine feeding the one-bit right shift
//               register stage. Accepts an operand, an unsigned shift amount
//               and a mode over a valid/ready handshake, shifts the operand
//               right by one bit per clock until the amount is consumed, and
//               returns the result over a second valid/ready handshake.
//               Mode: 0 = arithmetic (sign fill), 1 = logical (zero fill).
// Ports       : clk        rising-edge clock
//               rst_n      asynchronous active-low reset
//               in_valid   request present
//               in_ready   block can accept a request (IDLE)
//               in_data    operand, WIDTH bits
//               in_amt     shift count, AW bits, unsigned
//               in_mode    0 = arithmetic, 1 = logical
//               out_valid  result present (DONE)
//               out_ready  consumer accepts result
//               out_data   shifted result, WIDTH bits
//               busy       high in SHIFT or DONE
// Options     : RIGHT_SHIFT_SEQ_EARLY_DONE_EN - when defined, SHIFT exits to
//               DONE as soon as the data register equals the fill pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module right_shift_sequencer #(
    parameter  int WIDTH = 16,
    localparam int AW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AW-1:0]    in_amt,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [AW-1:0] C_WIDTH_AMT = AW'(WIDTH);
    localparam logic [AW-1:0] C_ONE       = AW'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [AW-1:0]    cnt_q,   cnt_d;
    logic             mode_q,  mode_d;

    logic [AW-1:0]    w_amt_sat;
    logic             w_fill_bit;
    logic [WIDTH-1:0] w_shifted;
    logic             w_at_fill;

    // Shifting by more than WIDTH yields the same result as shifting by WIDTH.
    assign w_amt_sat  = (in_amt > C_WIDTH_AMT) ? C_WIDTH_AMT : in_amt;

    // Logical mode fills with zero; arithmetic mode replicates the sign bit.
    assign w_fill_bit = ~mode_q & data_q[WIDTH-1];
    assign w_shifted  = {w_fill_bit, data_q[WIDTH-1:1]};

`ifdef RIGHT_SHIFT_SEQ_EARLY_DONE_EN
    // Once the register holds only fill bits, further shifts cannot change it.
    assign w_at_fill  = (data_q == {WIDTH{w_fill_bit}});
`else
    assign w_at_fill  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    mode_d  = in_mode;
                    cnt_d   = w_amt_sat;
                    state_d = (w_amt_sat == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_at_fill) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    data_d = w_shifted;
                    cnt_d  = cnt_q - C_ONE;
                    if (cnt_q == C_ONE) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    // All handshake outputs decode registered state only.
    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = data_q;

endmodule
`default_nettype wire
